// File: rtl/fsm_example_pkg.sv
// Shared types and widths for the fsm_example demonstration state machine.
// State names for logging exist only when FSM_LOG_EN is defined.
package fsm_example_pkg;

  localparam int TIMER_W = 8;
  localparam int LOOP_W  = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

`ifdef FSM_LOG_EN
  function automatic string state_name(input state_t s);
    case (s)
      IDLE:    return "IDLE";
      INIT:    return "INIT";
      RUN:     return "RUN";
      PAUSE:   return "PAUSE";
      DONE:    return "DONE";
      default: return "ILLEGAL";
    endcase
  endfunction
`endif

endpackage

// File: rtl/fsm_example_timer.sv
// Clearable cycle counter measuring dwell time in the current state.
module fsm_example_timer
  import fsm_example_pkg::*;
(
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               clr,
  output logic [TIMER_W-1:0] count
);

  // Count register: clears on request, otherwise advances by one
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count <= {TIMER_W{1'b0}};
    end else if (clr) begin
      count <= {TIMER_W{1'b0}};
    end else begin
      count <= count + TIMER_W'(1);
    end
  end

endmodule

// File: rtl/fsm_example.sv
// Self-running IDLE/INIT/RUN/PAUSE/DONE demonstration sequencer.
// Define FSM_LOG_EN to report transitions and illegal encodings in simulation.
module fsm_example
  import fsm_example_pkg::*;
#(
  parameter     NAME         = "fsm",
  parameter int INIT_CYCLES  = 4,
  parameter int RUN_CYCLES   = 8,
  parameter int PAUSE_CYCLES = 2,
  parameter int LOOPS        = 2
) (
  input logic aclk,
  input logic aresetn
);

  if (INIT_CYCLES < 1 || INIT_CYCLES > 256 ||
      RUN_CYCLES < 1 || RUN_CYCLES > 256 ||
      PAUSE_CYCLES < 1 || PAUSE_CYCLES > 256 ||
      LOOPS < 1 || LOOPS > 15 || NAME == 1'b0) begin : g_bad_params
    $error("fsm_example: parameter out of range");
  end

  state_t              state;
  state_t              next_state_s;
  logic [LOOP_W-1:0]   loop_cnt;
  logic [LOOP_W-1:0]   next_loop_s;
  logic [TIMER_W-1:0]  timer;
  logic                timer_clr_s;

  // Any change of state restarts the dwell counter, including illegal recovery
  assign timer_clr_s = (next_state_s != state);

  fsm_example_timer u_timer (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clr     (timer_clr_s),
    .count   (timer)
  );

  // Next-state and loop-count decision
  always_comb begin
    next_state_s = state;
    next_loop_s  = loop_cnt;
    case (state)
      IDLE: begin
        next_state_s = INIT;
      end
      INIT: begin
        if (timer == TIMER_W'(INIT_CYCLES - 1)) begin
          next_state_s = RUN;
        end else begin
          next_state_s = INIT;
        end
      end
      RUN: begin
        if (timer == TIMER_W'(RUN_CYCLES - 1)) begin
          next_state_s = PAUSE;
          next_loop_s  = loop_cnt + LOOP_W'(1);
        end else begin
          next_state_s = RUN;
        end
      end
      PAUSE: begin
        if (timer == TIMER_W'(PAUSE_CYCLES - 1)) begin
          if (loop_cnt < LOOP_W'(LOOPS)) begin
            next_state_s = RUN;
          end else begin
            next_state_s = DONE;
          end
        end else begin
          next_state_s = PAUSE;
        end
      end
      DONE: begin
        next_state_s = IDLE;
        next_loop_s  = {LOOP_W{1'b0}};
      end
      default: begin
        next_state_s = IDLE;
        next_loop_s  = {LOOP_W{1'b0}};
      end
    endcase
  end

  // State and loop-count registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      loop_cnt <= {LOOP_W{1'b0}};
    end else begin
      state    <= next_state_s;
      loop_cnt <= next_loop_s;
    end
  end

`ifdef FSM_LOG_EN
  // Transition log; reset is deliberately silent
  always @(posedge aclk) begin
    if (aresetn) begin
      if (!(state inside {IDLE, INIT, RUN, PAUSE, DONE})) begin
        $error("%s: illegal state encoding %0d", NAME, state);
      end else if (next_state_s != state) begin
        $info("%s: %s -> %s", NAME, state_name(state), state_name(next_state_s));
        if (state == DONE) begin
          $info("%s: sequence complete, %0d loops", NAME, LOOPS);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_fsm_example.sv
// Bench for fsm_example: default and short-loop instances compared each cycle
// against an arithmetic model of the state/timer/loop trace.
`timescale 1ns/100ps
module tb_fsm_example;
  import fsm_example_pkg::*;

  logic aclk    = 1'b1;
  logic aresetn = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  int   idx_a   = 0;
  int   idx_b   = 0;

  always #2 aclk = ~aclk;

  fsm_example dut (
    .aclk    (aclk),
    .aresetn (aresetn)
  );

  fsm_example #(.NAME("short"), .RUN_CYCLES(3), .LOOPS(1)) dut_s (
    .aclk    (aclk),
    .aresetn (aresetn)
  );

  task automatic check(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  // Expected (state, timer, loop_cnt) i cycles after the sequence starts in IDLE
  function automatic void expect_at(input int i, input int ic, input int rc,
                                    input int pc, input int loops,
                                    output int st, output int tm, output int lp);
    int p, c, k, r;
    p = 1 + ic + loops * (rc + pc) + 1;
    c = i % p;
    if (c == 0) begin
      st = 0; tm = 0; lp = 0;
    end else if (c - 1 < ic) begin
      st = 1; tm = c - 1; lp = 0;
    end else if (c - 1 - ic < loops * (rc + pc)) begin
      c = c - 1 - ic;
      k = c / (rc + pc);
      r = c % (rc + pc);
      if (r < rc) begin
        st = 2; tm = r; lp = k;
      end else begin
        st = 3; tm = r - rc; lp = k + 1;
      end
    end else begin
      st = 4; tm = 0; lp = loops;
    end
  endfunction

  task automatic check_a();
    int st, tm, lp;
    expect_at(idx_a, 4, 8, 2, 2, st, tm, lp);
    check($sformatf("a_state@%0d", idx_a), int'(dut.state), st);
    check($sformatf("a_timer@%0d", idx_a), int'(dut.timer), tm);
    check($sformatf("a_loop@%0d", idx_a), int'(dut.loop_cnt), lp);
  endtask

  task automatic check_b();
    int st, tm, lp;
    expect_at(idx_b, 4, 3, 2, 1, st, tm, lp);
    check($sformatf("b_state@%0d", idx_b), int'(dut_s.state), st);
    check($sformatf("b_timer@%0d", idx_b), int'(dut_s.timer), tm);
    check($sformatf("b_loop@%0d", idx_b), int'(dut_s.loop_cnt), lp);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge aclk);
      #1;
      idx_a++;
      idx_b++;
      check_a();
      check_b();
    end
  endtask

  // Called just after a rising edge; reset must act with no clock
  task automatic mid_reset();
    aresetn = 1'b0;
    #0.5;
    check("rst_a_state", int'(dut.state), 0);
    check("rst_a_timer", int'(dut.timer), 0);
    check("rst_a_loop", int'(dut.loop_cnt), 0);
    check("rst_b_state", int'(dut_s.state), 0);
    check("rst_b_timer", int'(dut_s.timer), 0);
    check("rst_b_loop", int'(dut_s.loop_cnt), 0);
    @(negedge aclk);
    aresetn = 1'b1;
    idx_a = 0;
    idx_b = 0;
    #0.5;
    check_a();
    check_b();
  endtask

  initial begin
    #5;
    check("por_state", int'(dut.state), 0);
    check("por_timer", int'(dut.timer), 0);
    check("por_loop", int'(dut.loop_cnt), 0);
    #5;
    aresetn = 1'b1;
    #1;
    check_a();
    check_b();

    // Reach RUN with timer 5, then reset mid-run
    step(10);
    check("run_t5_state", int'(dut.state), 2);
    check("run_t5_timer", int'(dut.timer), 5);
    mid_reset();

    step(60);
    repeat (4) begin
      step(int'($urandom_range(1, 40)));
      mid_reset();
      step(int'($urandom_range(1, 8)));
    end

    // Illegal encoding from PAUSE with a nonzero loop count
    mid_reset();
    step(14);
    check("pre_ill_loop", int'(dut.loop_cnt), 1);
    force dut.state = state_t'(3'd6);
    #0.5;
    release dut.state;
    #0.2;
    check("ill_held", int'(dut.state), 6);
    @(posedge aclk);
    #1;
    idx_a = 0;
    idx_b++;
    check("ill_state", int'(dut.state), 0);
    check("ill_timer", int'(dut.timer), 0);
    check("ill_loop", int'(dut.loop_cnt), 0);
    check_b();
    step(30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
